// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter requester block: index-width
// derivation, one-hot detection and the grant error-cause encoding.
package arb_pkg;

  localparam int ARB_MAX_N = 1024;
  localparam logic [ARB_MAX_N-1:0] ARB_ONE = {{(ARB_MAX_N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MULTI = 2'd1,
    ERR_IDLE  = 2'd2
  } err_cause_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Caller zero-extends its vector to ARB_MAX_N bits.
  function automatic logic is_onehot(input logic [ARB_MAX_N-1:0] v);
    logic [ARB_MAX_N-1:0] v_m1;
    v_m1 = v - ARB_ONE;
    return (v != '0) && ((v & v_m1) == '0);
  endfunction

endpackage

// File: rtl/arb_req_source_chk.sv
// Invariant checks for arb_req_source; observes ports only.
module arb_req_source_chk #(
  parameter int N = 32
) (
  input logic         clk,
  input logic         reset,
  input logic [N-1:0] req_o,
  input logic [N-1:0] full_o,
  input logic         ovf_o,
  input logic         clr_i
);

  a_full_implies_req: assert property (@(posedge clk) disable iff (!reset)
    ((full_o & ~req_o) == '0));

  a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset)
    (ovf_o && !clr_i) |=> ovf_o);

endmodule

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder, purely combinational.
// A zero input encodes to index 0.
module onehot_to_bin
  import arb_pkg::*;
#(
  parameter int N = 32,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     oh_i,
  output logic [IDX_W-1:0] bin_o
);

  // OR together the indices of all set bits.
  always_comb begin
    bin_o = '0;
    for (int k = 0; k < N; k++) begin
      if (oh_i[k]) begin
        bin_o = bin_o | IDX_W'(k);
      end else begin
        bin_o = bin_o;
      end
    end
  end

endmodule

// File: rtl/arb_req_source.sv
// Requester side of a single-cycle arbiter: saturating per-client pending
// counters, grant consumption and protocol checks. Optional grant statistics
// counter is enabled with ARB_REQ_SOURCE_STATS_EN.
module arb_req_source
  import arb_pkg::*;
#(
  parameter int N = 32,
  parameter int CNT_W = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     push_i,
  input  logic             clr_i,
  output logic [N-1:0]     req_o,
  input  logic [N-1:0]     gnt_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N-1:0]     full_o,
  output logic             ovf_o,
`ifdef ARB_REQ_SOURCE_STATS_EN
  output logic [15:0]      gnt_cnt_o,
`endif
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]     cnt_q [N];
  logic [CNT_W-1:0]     cnt_d [N];
  logic                 gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
`ifdef ARB_REQ_SOURCE_STATS_EN
  logic [15:0]          gnt_cnt_q, gnt_cnt_d;
`endif

  logic [ARB_MAX_N-1:0] gnt_ext_s;
  logic                 gnt_onehot_s;
  logic                 legal_s;
  logic                 err_evt_s;
  logic                 ovf_evt_s;
  logic [N-1:0]         dec_s;
  logic [IDX_W-1:0]     gnt_bin_s;

  // Status decode straight from the counter registers.
  always_comb begin
    req_o  = '0;
    full_o = '0;
    for (int k = 0; k < N; k++) begin
      req_o[k]  = (cnt_q[k] != '0);
      full_o[k] = (cnt_q[k] == CNT_MAX);
    end
  end

  onehot_to_bin #(.N(N)) u_enc (
    .oh_i  (gnt_i),
    .bin_o (gnt_bin_s)
  );

  // Classify the incoming grant; only a one-hot grant to a requester counts.
  always_comb begin
    gnt_ext_s        = '0;
    gnt_ext_s[N-1:0] = gnt_i;
    gnt_onehot_s     = is_onehot(gnt_ext_s);
    legal_s          = gnt_onehot_s && ((gnt_i & req_o) != '0);
    err_evt_s        = (gnt_i != '0) && !legal_s;
    if (legal_s) begin
      dec_s = gnt_i;
    end else begin
      dec_s = '0;
    end
  end

  // Saturating counter update; a same-cycle decrement makes room for a push.
  always_comb begin
    ovf_evt_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
      if (push_i[k] && !dec_s[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_evt_s = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end else if (dec_s[k] && !push_i[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_ONE;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Grant report and sticky flags; a new event beats a clear.
  always_comb begin
    gnt_valid_d = legal_s;
    if (legal_s) begin
      gnt_idx_d = gnt_bin_s;
    end else begin
      gnt_idx_d = gnt_idx_q;
    end
    ovf_d = ovf_evt_s | (ovf_q & ~clr_i);
    err_d = err_evt_s | (err_q & ~clr_i);
`ifdef ARB_REQ_SOURCE_STATS_EN
    if (legal_s) begin
      gnt_cnt_d = gnt_cnt_q + 16'd1;
    end else begin
      gnt_cnt_d = gnt_cnt_q;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_REQ_SOURCE_STATS_EN
      gnt_cnt_q   <= 16'd0;
`endif
    end else begin
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
`ifdef ARB_REQ_SOURCE_STATS_EN
      gnt_cnt_q   <= gnt_cnt_d;
`endif
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;
`ifdef ARB_REQ_SOURCE_STATS_EN
  assign gnt_cnt_o   = gnt_cnt_q;
`endif

  arb_req_source_chk #(.N(N)) u_chk (
    .clk    (clk),
    .reset  (reset),
    .req_o  (req_o),
    .full_o (full_o),
    .ovf_o  (ovf_o),
    .clr_i  (clr_i)
  );

endmodule

// File: tb/tb_arb_req_source.sv
// Directed bench for arb_req_source with N=4, CNT_W=2 (max pending 3).
module tb_arb_req_source;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] push_i;
  logic       clr_i;
  logic [3:0] req_o;
  logic [3:0] gnt_i;
  logic       gnt_valid_o;
  logic [1:0] gnt_idx_o;
  logic [3:0] full_o;
  logic       ovf_o;
  logic       err_o;
`ifdef ARB_REQ_SOURCE_STATS_EN
  logic [15:0] gnt_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  arb_req_source #(.N(4), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_i),
    .clr_i       (clr_i),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .full_o      (full_o),
    .ovf_o       (ovf_o),
`ifdef ARB_REQ_SOURCE_STATS_EN
    .gnt_cnt_o   (gnt_cnt_o),
`endif
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; push_i = 4'b0000; clr_i = 1'b0; gnt_i = 4'b0000;
    tick(); tick();
    reset = 1'b1;
    n_vec++; if (req_o !== 4'b0000) begin n_err++; $display("FAIL reset_req: got %b exp %b", req_o, 4'b0000); end
    n_vec++; if (full_o !== 4'b0000) begin n_err++; $display("FAIL reset_full: got %b exp %b", full_o, 4'b0000); end
    n_vec++; if (gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", gnt_valid_o); end
    n_vec++; if (gnt_idx_o !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d exp 0", gnt_idx_o); end
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b exp 0", ovf_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", err_o); end
  endtask

  task automatic test_push();
    push_i = 4'b0101;
    tick();
    push_i = 4'b0000;
    n_vec++; if (req_o !== 4'b0101) begin n_err++; $display("FAIL push_req: got %b exp %b", req_o, 4'b0101); end
    n_vec++; if (full_o !== 4'b0000) begin n_err++; $display("FAIL push_full: got %b exp %b", full_o, 4'b0000); end
    n_vec++; if (ovf_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL push_flags: got ovf=%b err=%b exp 0 0", ovf_o, err_o); end
  endtask

  task automatic test_grant();
    gnt_i = 4'b0100;
    tick();
    gnt_i = 4'b0000;
    n_vec++; if (gnt_valid_o !== 1'b1) begin n_err++; $display("FAIL grant_valid: got %b exp 1", gnt_valid_o); end
    n_vec++; if (gnt_idx_o !== 2'd2) begin n_err++; $display("FAIL grant_idx: got %0d exp 2", gnt_idx_o); end
    n_vec++; if (req_o !== 4'b0001) begin n_err++; $display("FAIL grant_req: got %b exp %b", req_o, 4'b0001); end
    tick();
    n_vec++; if (gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL grant_valid_drop: got %b exp 0", gnt_valid_o); end
    n_vec++; if (gnt_idx_o !== 2'd2) begin n_err++; $display("FAIL grant_idx_hold: got %0d exp 2", gnt_idx_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL grant_zero_noerr: got %b exp 0", err_o); end
    gnt_i = 4'b0001;
    tick();
    gnt_i = 4'b0000;
    n_vec++; if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd0) begin n_err++; $display("FAIL grant0: got valid=%b idx=%0d exp 1 0", gnt_valid_o, gnt_idx_o); end
    n_vec++; if (req_o !== 4'b0000) begin n_err++; $display("FAIL grant0_req: got %b exp %b", req_o, 4'b0000); end
  endtask

  task automatic test_overflow();
    push_i = 4'b0010;
    tick(); tick(); tick();
    n_vec++; if (full_o !== 4'b0010) begin n_err++; $display("FAIL ovf_full3: got %b exp %b", full_o, 4'b0010); end
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b exp 0", ovf_o); end
    tick();
    n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b exp 1", ovf_o); end
    tick();
    push_i = 4'b0000;
    n_vec++; if (full_o !== 4'b0010 || req_o !== 4'b0010) begin n_err++; $display("FAIL ovf_sat: got full=%b req=%b exp 0010 0010", full_o, req_o); end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b exp 0", ovf_o); end
    n_vec++; if (full_o !== 4'b0010) begin n_err++; $display("FAIL ovf_clr_cnt: got %b exp %b", full_o, 4'b0010); end
  endtask

  task automatic test_full_push_grant();
    push_i = 4'b0010; gnt_i = 4'b0010;
    tick();
    push_i = 4'b0000; gnt_i = 4'b0000;
    n_vec++; if (full_o !== 4'b0010) begin n_err++; $display("FAIL fpg_full: got %b exp %b", full_o, 4'b0010); end
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL fpg_ovf: got %b exp 0", ovf_o); end
    n_vec++; if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd1) begin n_err++; $display("FAIL fpg_gnt: got valid=%b idx=%0d exp 1 1", gnt_valid_o, gnt_idx_o); end
  endtask

  task automatic test_multi_hot();
    push_i = 4'b0100;
    tick();
    push_i = 4'b0000;
    gnt_i = 4'b0110;
    tick();
    gnt_i = 4'b0000;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL multi_err: got %b exp 1", err_o); end
    n_vec++; if (gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL multi_valid: got %b exp 0", gnt_valid_o); end
    n_vec++; if (req_o !== 4'b0110 || full_o !== 4'b0010) begin n_err++; $display("FAIL multi_cnt: got req=%b full=%b exp 0110 0010", req_o, full_o); end
    clr_i = 1'b1; gnt_i = 4'b0110;
    tick();
    gnt_i = 4'b0000;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL multi_setwins: got %b exp 1", err_o); end
    tick();
    clr_i = 1'b0;
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL multi_clr: got %b exp 0", err_o); end
  endtask

  task automatic test_idle_grant();
    gnt_i = 4'b1000;
    tick();
    gnt_i = 4'b0000;
    n_vec++; if (err_o !== 1'b1 || gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL idle_err: got err=%b valid=%b exp 1 0", err_o, gnt_valid_o); end
    n_vec++; if (req_o !== 4'b0110) begin n_err++; $display("FAIL idle_req: got %b exp %b", req_o, 4'b0110); end
`ifdef ARB_REQ_SOURCE_STATS_EN
    n_vec++; if (gnt_cnt_o !== 16'd3) begin n_err++; $display("FAIL stats_cnt: got %0d exp 3", gnt_cnt_o); end
`endif
  endtask

  task automatic test_reset_mid();
    push_i = 4'b1000;
    tick();
    gnt_i = 4'b0001;
    tick();
    push_i = 4'b0000; gnt_i = 4'b0000;
    n_vec++; if (req_o !== 4'b1110 || err_o !== 1'b1) begin n_err++; $display("FAIL mid_pre: got req=%b err=%b exp 1110 1", req_o, err_o); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++; if (req_o !== 4'b0000 || full_o !== 4'b0000) begin n_err++; $display("FAIL mid_req: got req=%b full=%b exp 0000 0000", req_o, full_o); end
    n_vec++; if (gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin n_err++; $display("FAIL mid_gnt: got valid=%b idx=%0d exp 0 0", gnt_valid_o, gnt_idx_o); end
    n_vec++; if (ovf_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL mid_flags: got ovf=%b err=%b exp 0 0", ovf_o, err_o); end
`ifdef ARB_REQ_SOURCE_STATS_EN
    n_vec++; if (gnt_cnt_o !== 16'd0) begin n_err++; $display("FAIL mid_stats: got %0d exp 0", gnt_cnt_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_push();
    test_grant();
    test_overflow();
    test_full_push_grant();
    test_multi_hot();
    test_idle_grant();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
